obstacle_spawner: RTL and testbench

//  Downstream consumer of the 3-bit LFSR lane generator. Each spawn tick (position == limit) places an obstacle in a free slot.

---
 rtl/obstacle_spawner_if.sv | 29 ++
 rtl/obstacle_spawner.sv | 141 ++++++++++++++
 tb/tb_obstacle_spawner.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/obstacle_spawner_if.sv
// Bus between the obstacle spawner and its driver: game controls, LFSR/spawn
// inputs, and the slot/score outputs feeding the renderer and score display.
interface obstacle_spawner_if #(
  parameter int NSLOT = 4
);
  logic                 start;
  logic                 scroll_en;
  logic [9:0]           position;
  logic [9:0]           limit;
  logic [2:0]           rnd_state;
  logic [1:0]           player_lane;
  logic [NSLOT-1:0]     obs_valid;
  logic [2*NSLOT-1:0]   obs_lane;
  logic [10*NSLOT-1:0]  obs_x;
  logic                 running;
  logic                 game_over;
  logic                 overflow;
  logic [15:0]          score;

  modport master (
    output start, scroll_en, position, limit, rnd_state, player_lane,
    input  obs_valid, obs_lane, obs_x, running, game_over, overflow, score
  );

  modport slave (
    input  start, scroll_en, position, limit, rnd_state, player_lane,
    output obs_valid, obs_lane, obs_x, running, game_over, overflow, score
  );
endinterface

// File: rtl/obstacle_spawner.sv
// Obstacle slot manager: spawns on LFSR ticks into free slots, scrolls them
// left, retires them into the score, and runs the IDLE/RUN/OVER game FSM.
module obstacle_spawner #(
  parameter int          NSLOT    = 4,
  parameter int          LANES    = 3,
  parameter logic [9:0]  X_START  = 10'd639,
  parameter logic [9:0]  SPEED    = 10'd2,
  parameter logic [9:0]  PLAYER_X = 10'd64,
  parameter logic [9:0]  PLAYER_W = 10'd16
) (
  input logic              clk,
  input logic              rst,
  obstacle_spawner_if.slave bus
);

  localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t           state;
  logic [NSLOT-1:0] valid_r;
  logic [1:0]       lane_r [NSLOT];
  logic [9:0]       x_r    [NSLOT];
  logic             running_r;
  logic             game_over_r;
  logic             overflow_r;
  logic [15:0]      score_r;

  logic             spawn_tick;
  logic             hit;
  logic             have_free;
  logic [IW-1:0]    free_idx;
  logic [2:0]       lane_mod;
  logic [1:0]       lane_new;
  logic [3:0]       retire_cnt;
  logic [16:0]      score_sum;

  always_comb begin
    spawn_tick = (bus.position == bus.limit);
    lane_mod   = bus.rnd_state % 3'(LANES);
    lane_new   = lane_mod[1:0];
    hit        = 1'b0;
    have_free  = 1'b0;
    free_idx   = '0;
    retire_cnt = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      if (valid_r[i] && (lane_r[i] == bus.player_lane) && (x_r[i] >= PLAYER_X) &&
          ({1'b0, x_r[i]} < ({1'b0, PLAYER_X} + {1'b0, PLAYER_W})))
        hit = 1'b1;
      if (!valid_r[i] && !have_free) begin
        have_free = 1'b1;
        free_idx  = IW'(i);
      end
      if (valid_r[i] && (x_r[i] < SPEED))
        retire_cnt = retire_cnt + 4'd1;
    end
    if (state != RUN)
      hit = 1'b0;
    score_sum = {1'b0, score_r} + 17'(retire_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      valid_r     <= '0;
      running_r   <= 1'b0;
      game_over_r <= 1'b0;
      overflow_r  <= 1'b0;
      score_r     <= '0;
      for (int unsigned i = 0; i < NSLOT; i++) begin
        lane_r[i] <= '0;
        x_r[i]    <= '0;
      end
    end else begin
      unique case (state)
        IDLE, OVER: begin
          if (bus.start) begin
            state       <= RUN;
            running_r   <= 1'b1;
            game_over_r <= 1'b0;
            valid_r     <= '0;
            overflow_r  <= 1'b0;
            score_r     <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
              lane_r[i] <= '0;
              x_r[i]    <= '0;
            end
          end
        end
        RUN: begin
          if (hit) begin
            state       <= OVER;
            running_r   <= 1'b0;
            game_over_r <= 1'b1;
          end else begin
            if (bus.scroll_en) begin
              for (int unsigned i = 0; i < NSLOT; i++) begin
                if (valid_r[i]) begin
                  if (x_r[i] >= SPEED) begin
                    x_r[i] <= x_r[i] - SPEED;
                  end else begin
                    valid_r[i] <= 1'b0;
                    x_r[i]     <= '0;
                  end
                end
              end
              score_r <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
            end
            // free_idx was invalid at cycle start, so the scroll loop never touches it
            if (spawn_tick) begin
              if (have_free) begin
                valid_r[free_idx] <= 1'b1;
                lane_r[free_idx]  <= lane_new;
                x_r[free_idx]     <= X_START;
              end else begin
                overflow_r <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.obs_lane = '0;
    bus.obs_x    = '0;
    for (int unsigned i = 0; i < NSLOT; i++) begin
      bus.obs_lane[2*i +: 2] = lane_r[i];
      bus.obs_x[10*i +: 10]  = x_r[i];
    end
  end

  assign bus.obs_valid = valid_r;
  assign bus.running   = running_r;
  assign bus.game_over = game_over_r;
  assign bus.overflow  = overflow_r;
  assign bus.score     = score_r;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: spawn/overflow, scroll/retire, hit,
// restart and reset behaviour with hand-computed expectations.
module tb_obstacle_spawner;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  obstacle_spawner_if #(.NSLOT(4)) bus ();

  obstacle_spawner #(
    .NSLOT(4), .LANES(3), .X_START(10'd639), .SPEED(10'd2),
    .PLAYER_X(10'd64), .PLAYER_W(10'd16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spawn(input logic [2:0] r);
    bus.rnd_state = r;
    bus.position  = 10'd5;
    bus.limit     = 10'd5;
    tick();
    bus.position  = 10'd0;
    bus.limit     = 10'd1;
  endtask

  task automatic scroll(input int n);
    bus.scroll_en = 1'b1;
    for (int k = 0; k < n; k++) tick();
    bus.scroll_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  function automatic logic [9:0] xs(input int i);
    logic [39:0] v;
    v = bus.obs_x;
    return v[10*i +: 10];
  endfunction

  function automatic logic [1:0] ln(input int i);
    logic [7:0] v;
    v = bus.obs_lane;
    return v[2*i +: 2];
  endfunction

  initial begin
    rst             = 1'b1;
    bus.start       = 1'b0;
    bus.scroll_en   = 1'b0;
    bus.position    = 10'd0;
    bus.limit       = 10'd1;
    bus.rnd_state   = 3'd0;
    bus.player_lane = 2'd3;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    chk("rst_valid", 32'(bus.obs_valid), 32'h0);
    chk("rst_lane", 32'(bus.obs_lane), 32'h0);
    chk("rst_x", 32'(bus.obs_x), 32'h0);
    chk("rst_score", 32'(bus.score), 32'h0);
    chk("rst_flags", {29'd0, bus.running, bus.game_over, bus.overflow}, 32'h0);

    // spawn tick in IDLE is ignored
    spawn(3'd5);
    chk("idle_spawn", 32'(bus.obs_valid), 32'h0);

    pulse_start();
    chk("start_run", {30'd0, bus.running, bus.game_over}, 32'h2);
    chk("start_valid", 32'(bus.obs_valid), 32'h0);

    // test 1: first spawn, lane 5%3=2
    spawn(3'd5);
    chk("t1_valid", 32'(bus.obs_valid), 32'h1);
    chk("t1_lane0", 32'(ln(0)), 32'd2);
    chk("t1_x0", 32'(xs(0)), 32'd639);

    // test 2: fill slots (lanes 0,1,1), fifth spawn dropped
    spawn(3'd0);
    spawn(3'd1);
    spawn(3'd4);
    chk("t2_valid4", 32'(bus.obs_valid), 32'hF);
    chk("t2_ovf0", 32'(bus.overflow), 32'h0);
    chk("t2_lanes", {24'd0, ln(3), ln(2), ln(1), ln(0)}, {24'd0, 2'd1, 2'd1, 2'd0, 2'd2});
    spawn(3'd2);
    chk("t2_ovf1", 32'(bus.overflow), 32'h1);
    chk("t2_valid_keep", 32'(bus.obs_valid), 32'hF);
    pulse_start();
    chk("t2_start_in_run", {30'd0, bus.overflow, bus.running}, 32'h3);
    chk("t2_start_valid", 32'(bus.obs_valid), 32'hF);

    // test 4: slot0 lane 2 reaches x=79 after 280 scrolls, hit follows
    bus.player_lane = 2'd2;
    scroll(280);
    chk("t4_x79", 32'(xs(0)), 32'd79);
    chk("t4_still_run", {30'd0, bus.running, bus.game_over}, 32'h2);
    scroll(1);
    chk("t4_over", {30'd0, bus.running, bus.game_over}, 32'h1);
    chk("t4_x_frozen", 32'(xs(0)), 32'd79);
    scroll(3);
    spawn(3'd0);
    chk("t4_x_frozen2", 32'(xs(0)), 32'd79);
    chk("t4_score", 32'(bus.score), 32'd0);
    chk("t4_valid_frozen", 32'(bus.obs_valid), 32'hF);

    // restart from OVER clears everything
    bus.player_lane = 2'd3;
    pulse_start();
    chk("t2_restart_valid", 32'(bus.obs_valid), 32'h0);
    chk("t2_restart_flags", {29'd0, bus.running, bus.game_over, bus.overflow}, 32'h4);
    chk("t2_restart_x", 32'(bus.obs_x), 32'h0);

    // test 3: x=3 -> 1 -> retire, simultaneous spawn goes to slot1
    spawn(3'd1);
    scroll(318);
    chk("t3_x3", 32'(xs(0)), 32'd3);
    scroll(1);
    chk("t3_x1", 32'(xs(0)), 32'd1);
    bus.rnd_state = 3'd3;
    bus.position  = 10'd7;
    bus.limit     = 10'd7;
    bus.scroll_en = 1'b1;
    tick();
    bus.scroll_en = 1'b0;
    bus.position  = 10'd0;
    bus.limit     = 10'd1;
    chk("t3_valid", 32'(bus.obs_valid), 32'h2);
    chk("t3_score", 32'(bus.score), 32'd1);
    chk("t3_x0_clr", 32'(xs(0)), 32'd0);
    chk("t3_x1_new", 32'(xs(1)), 32'd639);
    chk("t3_lane1", 32'(ln(1)), 32'd0);

    // test 5: slot1 lane 0, player lane 1 -> passes hit box, retires
    bus.player_lane = 2'd1;
    scroll(280);
    chk("t5_x79", 32'(xs(1)), 32'd79);
    scroll(1);
    chk("t5_no_hit", {30'd0, bus.running, bus.game_over}, 32'h2);
    chk("t5_x77", 32'(xs(1)), 32'd77);
    scroll(39);
    chk("t5_retired", 32'(bus.obs_valid), 32'h0);
    chk("t5_score", 32'(bus.score), 32'd2);
    chk("t5_running", 32'(bus.running), 32'h1);

    // test 6: rst with start high mid-RUN
    bus.player_lane = 2'd3;
    spawn(3'd0);
    spawn(3'd1);
    spawn(3'd2);
    chk("t6_valid3", 32'(bus.obs_valid), 32'h7);
    rst       = 1'b1;
    bus.start = 1'b1;
    tick();
    rst       = 1'b0;
    bus.start = 1'b0;
    chk("t6_valid", 32'(bus.obs_valid), 32'h0);
    chk("t6_xlane", 32'(bus.obs_x) | 32'(bus.obs_lane), 32'h0);
    chk("t6_flags", {29'd0, bus.running, bus.game_over, bus.overflow}, 32'h0);
    chk("t6_score", 32'(bus.score), 32'h0);
    spawn(3'd1);
    chk("t6_idle", 32'(bus.obs_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
